// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Serial-to-parallel UART receiver for 8N1 frames sent LSB first. This is the
// laptop-to-FPGA path that loads FIR coefficients. Each correctly framed byte
// appears on uart_data together with a one-cycle uart_done strobe. The strobe
// also drives the sender's uart_en input so the byte is echoed back.
//
// Optional build macro: UART_RX_PARITY_EN
//   undefined : 8N1. The PARITY state is never entered and parity_err is
//               tied to 0.
//   defined   : 8E1. An even-parity bit is expected between the last data
//               bit and the stop bit. On a mismatch (with a good stop bit)
//               parity_err pulses instead of uart_done.
//   The port list is the same in both builds.
//
// Parameters
//   CLK_FREQ : system clock frequency in Hz
//   UART_BPS : line bit rate. CLK_FREQ/UART_BPS must lie in 4..65535.
//
// Ports
//   sys_clk    in   system clock; all logic runs on the rising edge
//   sys_rst    in   asynchronous, active-low reset
//   uart_rxd   in   serial line, idle high, asynchronous to sys_clk
//   uart_done  out  one-cycle pulse: new valid byte on uart_data
//   uart_data  out  last correctly received byte, held until the next one
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   parity_err out  one-cycle pulse: parity mismatch (parity build only)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_receiver #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic       uart_done,
  output logic [7:0] uart_data,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned BPS_CNT   = CLK_FREQ / UART_BPS;
  // The sample point is mid-bit, measured from the detected start edge.
  localparam logic [15:0] SAMPLE_PT = 16'(BPS_CNT / 2);
  localparam logic [15:0] BIT_LAST  = 16'(BPS_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

  // Input conditioning: a two-flop synchronizer plus one delay flop for the
  // edge detector.
  logic rx_s1_q, rx_s1_d;
  logic rx_s2_q, rx_s2_d;
  logic rx_d_q,  rx_d_d;

  state_e      state_q,   state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q,   shift_d;
  logic [7:0]  data_q,    data_d;
  logic        done_q,    done_d;
  logic        ferr_q,    ferr_d;

`ifdef UART_RX_PARITY_EN
  logic        perr_q,    perr_d;
  logic        par_bad_q, par_bad_d;
`endif

  logic        fall;
  logic        sample;
  logic        bit_end;
  logic [15:0] cnt_inc;

  assign fall    = rx_d_q & ~rx_s2_q;
  assign sample  = (clk_cnt_q == SAMPLE_PT);
  assign bit_end = (clk_cnt_q == BIT_LAST);
  assign cnt_inc = bit_end ? 16'd0 : clk_cnt_q + 16'd1;

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    rx_s1_d   = uart_rxd;
    rx_s2_d   = rx_s1_q;
    rx_d_d    = rx_s2_q;
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = 16'd0;
        bit_cnt_d = 4'd0;
        if (fall) begin
          state_d = START;
        end
      end

      START: begin
        clk_cnt_d = cnt_inc;
        if (sample && rx_s2_q) begin
          // The line is high again at mid-bit, so the edge was a glitch.
          state_d   = IDLE;
          clk_cnt_d = 16'd0;
        end else if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = 4'd0;
        end
      end

      DATA: begin
        clk_cnt_d = cnt_inc;
        if (sample) begin
          // Shift in at the MSB so the first (LSB) bit ends up at bit 0.
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (bit_end && bit_cnt_q == 4'd8) begin
          bit_cnt_d = 4'd0;
`ifdef UART_RX_PARITY_EN
          state_d   = PARITY;
`else
          state_d   = STOP;
`endif
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        clk_cnt_d = cnt_inc;
        if (sample) begin
          // Even parity: the data bits and the parity bit XOR to 0.
          par_bad_d = ^{shift_q, rx_s2_q};
        end
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        clk_cnt_d = cnt_inc;
        if (sample) begin
          clk_cnt_d = 16'd0;
          if (rx_s2_q) begin
            // Return to IDLE at mid-stop-bit. This leaves half a bit of
            // slack to catch a start bit that follows with no idle gap.
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d = shift_q;
              done_d = 1'b1;
            end
`else
            data_d = shift_q;
            done_d = 1'b1;
`endif
          end else begin
            // A bad stop bit takes priority over any parity result.
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end

      BREAK: begin
        // Wait out a held-low line. Edges inside it are not start bits.
        clk_cnt_d = 16'd0;
        if (rx_s2_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        clk_cnt_d = 16'd0;
        bit_cnt_d = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      // NOTE: the synchronizer resets to the idle-high level, so releasing
      // reset can never look like a falling start edge.
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_d_q    <= 1'b1;
      state_q   <= IDLE;
      clk_cnt_q <= 16'd0;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments. Every flop updates from the values
      // that were present before the edge.
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_d_q    <= rx_d_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign uart_done = done_q;
  assign uart_data = data_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//
// Scoreboard bench for uart_receiver. The stimulus side serialises frames on
// uart_rxd. For each frame it pushes the expected response into a queue. The
// expected response is derived from the frame contents only: a bad stop bit
// gives frame_err, a parity mismatch gives parity_err, and anything else
// gives uart_done with the byte. An independent monitor pops one entry for
// every output pulse. It checks the pulse kind, the held uart_data value and
// the latency from the start edge.
//
// The bit clock is scaled down (BPS_CNT = 64) so that the run stays short.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_receiver;

  localparam int CLK_FREQ = 640_000;
  localparam int UART_BPS = 10_000;
  localparam int B        = CLK_FREQ / UART_BPS;   // clocks per bit
  localparam int CLK_NS   = 10;
  localparam int BIT_NS   = B * CLK_NS;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN     = 1'b1;
  localparam int FRAME_BITS = 11;
`else
  localparam bit PAR_EN     = 1'b0;
  localparam int FRAME_BITS = 10;
`endif

  // Latency from the first clock edge that sees the start bit low.
  localparam int EXP_LAT = 2 + B / 2 + 9 * B + (PAR_EN ? B : 0);

  localparam logic [2:0] K_DONE = 3'b100;
  localparam logic [2:0] K_FERR = 3'b010;
  localparam logic [2:0] K_PERR = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         cyc0;
    bit         chk_lat;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_done;
  logic [7:0] uart_data;
  logic       frame_err;
  logic       parity_err;

  exp_t       sb_q[$];
  logic [7:0] exp_hold = 8'h00;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         pulses   = 0;
  int         cyc      = 0;
  bit         prev_any = 1'b0;

  uart_receiver #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .uart_rxd   (uart_rxd),
    .uart_done  (uart_done),
    .uart_data  (uart_data),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #(CLK_NS / 2) sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_cond(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    bit   any;
    exp_t e;
    int   lat;
    if (!sys_rst) begin
      prev_any = 1'b0;
    end else begin
      any = uart_done | frame_err | parity_err;
      if (any) begin
        pulses++;
        check("pulse_exclusive", 32'(uart_done) + 32'(frame_err) + 32'(parity_err), 32'd1);
        check("pulse_spacing", 32'(prev_any), 32'd0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got done=%0b ferr=%0b perr=%0b, expected none",
                   uart_done, frame_err, parity_err);
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind", {29'd0, uart_done, frame_err, parity_err}, {29'd0, e.kind});
          if (e.kind == K_DONE) exp_hold = e.data;
          check("uart_data", {24'd0, uart_data}, {24'd0, exp_hold});
          if (e.chk_lat) begin
            lat = cyc - (e.cyc0 + 1);
            check_cond("latency", (lat >= EXP_LAT - 1) && (lat <= EXP_LAT + 1), lat, EXP_LAT);
          end
        end
      end
      prev_any = any;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive the first nbits bits of a frame: start, data LSB first, [parity], stop.
  task automatic tx_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                          input int bit_ns, input int nbits);
    logic [10:0] fr;
    fr      = 11'h7FF;
    fr[0]   = 1'b0;
    fr[8:1] = d;
    if (PAR_EN) begin
      fr[9]  = par_b;
      fr[10] = stop_b;
    end else begin
      fr[9]  = stop_b;
    end
    for (int i = 0; i < nbits; i++) begin
      uart_rxd = fr[i];
      #(bit_ns);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit good_stop, input bit good_par,
                      input int err_ns, input int gap_bits, input int low_hold_bits);
    exp_t e;
    int   bit_ns;
    logic par_b;
    bit_ns    = BIT_NS + err_ns;
    par_b     = (^d) ^ ~good_par;
    e.kind    = !good_stop ? K_FERR : ((PAR_EN && !good_par) ? K_PERR : K_DONE);
    e.data    = d;
    e.cyc0    = cyc;
    e.chk_lat = (err_ns == 0);
    sb_q.push_back(e);
    tx_frame(d, good_stop, par_b, bit_ns, FRAME_BITS);
    if (!good_stop) begin
      #(low_hold_bits * bit_ns);
      uart_rxd = 1'b1;
    end
    #(gap_bits * bit_ns);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3 * FRAME_BITS * B && sb_q.size() != 0; i++) @(negedge sys_clk);
    check("drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic align();
    @(negedge sys_clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int p0;
    logic [7:0] d;
    bit gs, gp;
    int err, gap;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_done", 32'(uart_done), 32'd0);
    check("rst_data", {24'd0, uart_data}, 32'h00);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    align();
    sys_rst = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("idle_no_pulse", 32'(pulses), 32'd0);

    // Single byte, nominal rate
    align();
    send(8'hA5, 1'b1, 1'b1, 0, 2, 0);
    wait_drain();

    // Back-to-back, no idle gap
    align();
    send(8'h00, 1'b1, 1'b1, 0, 0, 0);
    send(8'hFF, 1'b1, 1'b1, 0, 0, 0);
    send(8'h55, 1'b1, 1'b1, 0, 2, 0);
    wait_drain();

    // Short low glitch on an idle line
    p0 = pulses;
    align();
    uart_rxd = 1'b0;
    #(20 * CLK_NS);
    uart_rxd = 1'b1;
    #(3 * BIT_NS);
    check("glitch_no_pulse", 32'(pulses), 32'(p0));
    check("glitch_data", {24'd0, uart_data}, {24'd0, exp_hold});
    send(8'h3C, 1'b1, 1'b1, 0, 2, 0);
    wait_drain();

    // Stop bit low, line held low for 3 more bits
    align();
    send(8'h81, 1'b0, 1'b1, 0, 1, 3);
    send(8'h42, 1'b1, 1'b1, 0, 2, 0);
    wait_drain();

    // Reset in the middle of the data bits
    p0 = pulses;
    align();
    tx_frame(8'hC3, 1'b1, ^8'hC3, BIT_NS, 5);
    sys_rst  = 1'b0;
    exp_hold = 8'h00;
    @(negedge sys_clk);
    check("midrst_data", {24'd0, uart_data}, 32'h00);
    uart_rxd = 1'b1;
    align();
    sys_rst = 1'b1;
    #(2 * BIT_NS);
    check("midrst_no_pulse", 32'(pulses), 32'(p0));
    send(8'h18, 1'b1, 1'b1, 0, 2, 0);
    wait_drain();
    check("after_rst_data", {24'd0, uart_data}, 32'h18);

`ifdef UART_RX_PARITY_EN
    align();
    send(8'h07, 1'b1, 1'b1, 0, 1, 0);
    send(8'h07, 1'b1, 1'b0, 0, 2, 0);
    wait_drain();
`endif

    // Randomized frames with sender rate error of about +/-3%
    align();
    for (int n = 0; n < 30; n++) begin
      d   = 8'($urandom);
      gs  = ($urandom_range(0, 9) != 0);
      gp  = PAR_EN ? ($urandom_range(0, 6) != 0) : 1'b1;
      err = 10 * int'($urandom_range(0, 4)) - 20;
      gap = gs ? int'($urandom_range(0, 2)) : 1;
      send(d, gs, gp, err, gap, 1);
    end
    #(2 * BIT_NS);
    wait_drain();
    check("final_data", {24'd0, uart_data}, {24'd0, exp_hold});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(800_000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver, 8N1 frames, LSB first. It is the laptop-to-FPGA path for loading FIR coefficients.
- Samples the asynchronous line `uart_rxd`, validates start and stop bits, and presents each byte as `uart_data` with a one-cycle `uart_done` strobe.
- `uart_done` drives the sender's `uart_en` input for echo-back, and feeds the coefficient loader.

Parameters:
- `CLK_FREQ`, 50000000, system clock frequency in Hz.
- `UART_BPS`, 9600, line bit rate.
- `BPS_CNT` (localparam), `CLK_FREQ/UART_BPS`, clocks per bit. Must satisfy 4 <= `BPS_CNT` <= 65535.

Ports:
- `sys_clk`  input  1  system clock, all logic on posedge.
- `sys_rst`  input  1  asynchronous, active-low reset.
- `uart_rxd`  input  1  serial line, idle high, asynchronous to `sys_clk`.
- `uart_done`  output  1  one-cycle pulse: valid byte on `uart_data`.
- `uart_data`  output  8  last correctly received byte; held until the next valid frame.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  output  1  one-cycle pulse: parity mismatch (see Optional Feature).

Behaviour:
- Reset (`sys_rst`=0, asynchronous): state=IDLE, counters=0.
  - `uart_done`=0, `uart_data`=8'h00, `frame_err`=0, `parity_err`=0.
  - Synchronizer flops reset to 1, so reset release never produces a false start edge.
- Input conditioning:
  - Two-flop synchronizer `rx_s1`→`rx_s2`, plus a third flop `rx_d` for edge detection.
  - `fall` = `rx_d` & ~`rx_s2`.
- Counters:
  - `clk_cnt` is 16 bit and counts 0..`BPS_CNT`-1, then wraps to 0.
  - `bit_cnt` is 4 bit.
  - Sample point is `clk_cnt` == `BPS_CNT`/2 (integer division).
- States:
  - IDLE: counters held at 0. `fall` → START, with `clk_cnt` cleared.
  - START: at the sample point, if `rx_s2`=1 the edge was a glitch → IDLE, no output pulses. If `rx_s2`=0 → DATA at the bit boundary.
  - DATA: 8 bits. At each sample point, shift `rx_s2` into `shift_reg` at MSB (LSB-first result). After the 8th bit → STOP (or PARITY if enabled) at the bit boundary.
  - STOP: at the sample point:
    - `rx_s2`=1: `uart_data`<=`shift_reg`, `uart_done`=1 for exactly 1 cycle, → IDLE immediately (mid-stop-bit), so back-to-back frames are caught.
    - `rx_s2`=0: `frame_err`=1 for 1 cycle, `uart_data` unchanged, → BREAK.
  - BREAK: wait until `rx_s2`=1, then → IDLE. Edges during a held-low line are ignored.
- Latency: `uart_done` asserts 2 + (`BPS_CNT`/2) + 9·`BPS_CNT` (±1) clocks after `uart_rxd` falls.
  - Clocks are counted from the first `sys_clk` edge that sees the low level.
- Pulse rules: `uart_done`, `frame_err` and `parity_err` are mutually exclusive and never asserted in consecutive cycles.
- Busy rules:
  - A `fall` while not in IDLE has no effect.
  - Reset mid-frame aborts immediately with no pulse. After release, the next falling edge begins a fresh frame.
- Tolerance: correct reception for transmitter bit-rate error up to ±4%.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - A PARITY state is inserted between DATA and STOP. The bit is sampled at mid-bit; even parity is required (XOR of the 8 data bits and the parity bit = 0).
  - On mismatch, the STOP sample still occurs. If the stop bit is good: `parity_err` pulses for 1 cycle, `uart_done` is suppressed and `uart_data` is unchanged.
  - A bad stop bit takes priority: `frame_err` pulses, not `parity_err`.
  - Latency grows by `BPS_CNT`.
- Undefined: no PARITY state and `parity_err` is tied to constant 0. The port list is identical in both builds.

Test Plan:
- Send 8'hA5 at 9600 with a 1 stop bit → one `uart_done` pulse at ~9.5 bit times (~49476 clks) after the edge, `uart_data`=8'hA5, no error pulses.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap → three `uart_done` pulses ~52080 clks apart, with `uart_data` 00, FF, 55 in order.
- 1000-clk low glitch on an idle line → START aborts, no pulses, `uart_data` unchanged. A following 8'h3C is received correctly.
- Frame 8'h81 with stop bit forced low, line then held low 3 bit times before going high → `frame_err` 1 pulse, no `uart_done`, `uart_data` keeps the previous value. A following 8'h42 is received correctly.
- Assert `sys_rst` mid-DATA of 8'hC3, then release and send 8'h18 → no pulse for the aborted frame, `uart_data`=8'h18 after the second frame. Repeat at `UART_BPS`=115200 (`BPS_CNT`=434) with ±3% sender rate → correct bytes.
- With `UART_RX_PARITY_EN`:
  - 8'h07 with parity 1 → `uart_done`, `uart_data`=8'h07.
  - 8'h07 with parity 0 → `parity_err` pulse only, `uart_data` unchanged.
